// File: rtl/irs_monitor_pkg.sv
// -----------------------------------------------------------------------------
// irs_monitor_pkg
// Shared definitions for the IRS occupancy monitor:
//   - default parameter values
//   - IDLE/DEAD state encoding of the trigger-inhibit register
//   - width helper for saturating additions
// -----------------------------------------------------------------------------
package irs_monitor_pkg;

    localparam int DEF_CNT_WIDTH       = 9;
    localparam int DEF_REQ_WIDTH       = 3;
    localparam int DEF_STAT_WIDTH      = 8;
    localparam int DEF_DEAD_CNT_WIDTH  = 20;
    localparam int DEF_OCC_WINDOW_LOG2 = 4;
    localparam int DEF_HYST_CYCLES     = 4;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_DEAD = 1'b1
    } dead_state_t;

    // Width needed to hold a + b without wrapping, so saturation can be
    // detected from the carry bit.
    function automatic int sat_add_width(input int a_w, input int b_w);
        return ((a_w > b_w) ? a_w : b_w) + 1;
    endfunction

endpackage

// File: rtl/irs_pps_stat_counter.sv
// -----------------------------------------------------------------------------
// irs_pps_stat_counter
// Saturating event counter with a PPS latch/clear. On pps_i the top OUT_WIDTH
// bits of the accumulator are latched into stat_o and the accumulator restarts.
// KEEP_PPS_INC selects whether an increment on the pps cycle seeds the new
// second (1) or is dropped (0).
// Ports:
//   clk_i   system clock
//   rst_i   synchronous active-high reset
//   inc_i   count enable
//   pps_i   latch-and-clear strobe
//   stat_o  latched statistic (OUT_WIDTH)
// -----------------------------------------------------------------------------
module irs_pps_stat_counter
    import irs_monitor_pkg::*;
#(
    parameter int ACC_WIDTH    = DEF_DEAD_CNT_WIDTH,
    parameter int OUT_WIDTH    = DEF_STAT_WIDTH,
    parameter bit KEEP_PPS_INC = 1'b0
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 inc_i,
    input  logic                 pps_i,
    output logic [OUT_WIDTH-1:0] stat_o
);

    logic [ACC_WIDTH-1:0] acc_reg;
    logic [OUT_WIDTH-1:0] stat_reg;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            acc_reg  <= '0;
            stat_reg <= '0;
        end else if (pps_i) begin
            stat_reg <= acc_reg[ACC_WIDTH-1 -: OUT_WIDTH];
            acc_reg  <= (KEEP_PPS_INC && inc_i) ? ACC_WIDTH'(1) : '0;
        end else if (inc_i && (acc_reg != '1)) begin
            acc_reg <= acc_reg + ACC_WIDTH'(1);
        end
    end

    assign stat_o = stat_reg;

endmodule

// File: rtl/irs_occupancy_monitor.sv
// -----------------------------------------------------------------------------
// irs_occupancy_monitor
// Tracks the number of locked IRS blocks, drives a trigger inhibit with
// high/low water marks plus exit hysteresis, and produces per-PPS statistics
// (deadtime, windowed average occupancy, max occupancy, inhibited triggers).
// Optional macro IRS_OCC_ERR_EN enables sticky overflow/underflow flags on
// err_o; without it err_o is tied to 0 and err_clr_i is ignored.
// Ports:
//   clk_i, rst_i             clock, synchronous active-high reset
//   slow_ce_i, micro_ce_i    occupancy sample strobe, deadtime tick strobe
//   pps_i                    statistics latch strobe
//   block_req_i/done_i       blocks locked / freed this cycle
//   trig_i                   trigger arrival
//   high_water_i/low_water_i dead entry / exit thresholds
//   irs_dead_i               external dead, ORed into dead_o
//   err_clr_i                clears err_o
//   dead_o                   trigger inhibit
//   deadtime_o, occupancy_o, max_occupancy_o, inhibit_count_o  statistics
//   err_o                    [0] overflow, [1] underflow
// -----------------------------------------------------------------------------
module irs_occupancy_monitor
    import irs_monitor_pkg::*;
#(
    parameter int CNT_WIDTH       = DEF_CNT_WIDTH,
    parameter int REQ_WIDTH       = DEF_REQ_WIDTH,
    parameter int STAT_WIDTH      = DEF_STAT_WIDTH,
    parameter int DEAD_CNT_WIDTH  = DEF_DEAD_CNT_WIDTH,
    parameter int OCC_WINDOW_LOG2 = DEF_OCC_WINDOW_LOG2,
    parameter int HYST_CYCLES     = DEF_HYST_CYCLES
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  slow_ce_i,
    input  logic                  micro_ce_i,
    input  logic                  pps_i,
    input  logic [REQ_WIDTH-1:0]  block_req_i,
    input  logic [REQ_WIDTH-1:0]  block_done_i,
    input  logic                  trig_i,
    input  logic [CNT_WIDTH-1:0]  high_water_i,
    input  logic [CNT_WIDTH-1:0]  low_water_i,
    input  logic                  irs_dead_i,
    input  logic                  err_clr_i,
    output logic                  dead_o,
    output logic [STAT_WIDTH-1:0] deadtime_o,
    output logic [STAT_WIDTH-1:0] occupancy_o,
    output logic [STAT_WIDTH-1:0] max_occupancy_o,
    output logic [STAT_WIDTH-1:0] inhibit_count_o,
    output logic [1:0]            err_o
);

    localparam int SUM_W    = sat_add_width(CNT_WIDTH, REQ_WIDTH);
    localparam int OCC_W    = CNT_WIDTH + OCC_WINDOW_LOG2;
    localparam int HYST_W   = $clog2(HYST_CYCLES + 1);
    localparam int STAT_MAX = (2 ** STAT_WIDTH) - 1;

    // ---------------- block counter ----------------
    logic [CNT_WIDTH-1:0] count_reg, count_next;
    logic [SUM_W-1:0]     req_sum;
    logic [SUM_W-1:0]     done_ext;
    logic                 ovf_evt, udf_evt;

    always_comb begin
        req_sum    = SUM_W'(count_reg) + SUM_W'(block_req_i);
        done_ext   = SUM_W'(block_done_i);
        ovf_evt    = 1'b0;
        udf_evt    = 1'b0;
        count_next = count_reg;
        if (done_ext > req_sum) begin
            // Release larger than what is held: clamp at empty.
            udf_evt    = 1'b1;
            count_next = '0;
        end else if ((req_sum - done_ext) > SUM_W'({CNT_WIDTH{1'b1}})) begin
            ovf_evt    = 1'b1;
            count_next = '1;
        end else begin
            count_next = CNT_WIDTH'(req_sum - done_ext);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) count_reg <= '0;
        else       count_reg <= count_next;
    end

    // ---------------- dead FSM ----------------
    dead_state_t          state_reg, state_next;
    logic [HYST_W-1:0]    hyst_reg, hyst_next, hyst_inc;
    logic [CNT_WIDTH-1:0] low_eff;
    logic                 below_low;
    logic                 dead_reg;

    // A low mark above the high mark would make exit impossible to reason
    // about, so the high mark doubles as the exit threshold in that case.
    assign low_eff   = (low_water_i > high_water_i) ? high_water_i : low_water_i;
    assign below_low = (count_reg < low_eff);
    assign hyst_inc  = hyst_reg + HYST_W'(1);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_reg <= ST_IDLE;
            hyst_reg  <= '0;
        end else begin
            state_reg <= state_next;
            hyst_reg  <= hyst_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        hyst_next  = '0;
        case (state_reg)
            ST_IDLE: begin
                if (count_reg >= high_water_i) state_next = ST_DEAD;
            end
            ST_DEAD: begin
                if (below_low) begin
                    if (hyst_inc == HYST_W'(HYST_CYCLES)) state_next = ST_IDLE;
                    else                                  hyst_next  = hyst_inc;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        dead_reg = (state_reg == ST_DEAD);
    end

    assign dead_o = dead_reg | irs_dead_i;

    // ---------------- per-PPS event counters ----------------
    irs_pps_stat_counter #(
        .ACC_WIDTH   (DEAD_CNT_WIDTH),
        .OUT_WIDTH   (STAT_WIDTH),
        .KEEP_PPS_INC(1'b0)
    ) u_deadtime (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .inc_i (micro_ce_i & dead_o),
        .pps_i (pps_i),
        .stat_o(deadtime_o)
    );

    irs_pps_stat_counter #(
        .ACC_WIDTH   (STAT_WIDTH),
        .OUT_WIDTH   (STAT_WIDTH),
        .KEEP_PPS_INC(1'b1)
    ) u_inhibit (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .inc_i (trig_i & dead_o),
        .pps_i (pps_i),
        .stat_o(inhibit_count_o)
    );

    // ---------------- windowed occupancy average ----------------
    logic [OCC_W-1:0]           occ_acc_reg;
    logic [OCC_W-1:0]           occ_sum;
    logic [OCC_W-1:0]           occ_avg;
    logic [OCC_WINDOW_LOG2-1:0] sample_cnt_reg;
    logic [STAT_WIDTH-1:0]      occupancy_reg;

    assign occ_sum = occ_acc_reg + OCC_W'(count_reg);
    assign occ_avg = occ_sum >> OCC_WINDOW_LOG2;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            occ_acc_reg    <= '0;
            sample_cnt_reg <= '0;
            occupancy_reg  <= '0;
        end else if (slow_ce_i) begin
            sample_cnt_reg <= sample_cnt_reg + OCC_WINDOW_LOG2'(1);
            if (sample_cnt_reg == '1) begin
                occ_acc_reg   <= '0;
                occupancy_reg <= (occ_avg > OCC_W'(STAT_MAX)) ? '1 : occ_avg[STAT_WIDTH-1:0];
            end else begin
                occ_acc_reg <= occ_sum;
            end
        end
    end

    assign occupancy_o = occupancy_reg;

    // ---------------- per-second max occupancy ----------------
    logic [CNT_WIDTH-1:0]  run_max_reg;
    logic [STAT_WIDTH-1:0] max_occ_reg;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            run_max_reg <= '0;
            max_occ_reg <= '0;
        end else if (pps_i) begin
            max_occ_reg <= (run_max_reg > CNT_WIDTH'(STAT_MAX)) ? '1 : run_max_reg[STAT_WIDTH-1:0];
            // The new second already holds the current count.
            run_max_reg <= count_reg;
        end else if (count_reg > run_max_reg) begin
            run_max_reg <= count_reg;
        end
    end

    assign max_occupancy_o = max_occ_reg;

    // ---------------- optional sticky error flags ----------------
`ifdef IRS_OCC_ERR_EN
    logic [1:0] err_reg;
    logic [1:0] err_set;

    assign err_set = {udf_evt, ovf_evt};

    for (genvar gi = 0; gi < 2; gi++) begin : g_err
        // Set has priority over a same-cycle clear.
        always_ff @(posedge clk_i) begin
            if (rst_i)            err_reg[gi] <= 1'b0;
            else if (err_set[gi]) err_reg[gi] <= 1'b1;
            else if (err_clr_i)   err_reg[gi] <= 1'b0;
        end
    end

    assign err_o = err_reg;
`else
    logic err_unused;
    assign err_unused = err_clr_i ^ ovf_evt ^ udf_evt;
    assign err_o      = 2'b00;
`endif

endmodule

// File: doc/irs_occupancy_monitor.md
Name: irs_occupancy_monitor

Overview:
- Parametrised successor to the IRS block monitor.
- Tracks the number of locked IRS blocks; supports multi-block requests and releases per cycle.
- Asserts a trigger-inhibit (dead) with separate, runtime-programmable high and low water marks.
- Produces per-PPS statistics for the housekeeping register file: deadtime, average and max occupancy, and count of inhibited triggers.

Parameters:
- CNT_WIDTH, 9: width of the locked-block counter (up to 511 blocks).
- REQ_WIDTH, 3: width of the per-cycle request and release counts.
- STAT_WIDTH, 8: width of every latched statistic output.
- DEAD_CNT_WIDTH, 20: deadtime accumulator width; output is its top STAT_WIDTH bits.
- OCC_WINDOW_LOG2, 4: log2 of the number of slow_ce_i samples per occupancy average.
- HYST_CYCLES, 4: consecutive cycles below the low water mark required to leave dead.

Ports:
- clk_i  in  1  system clock.
- rst_i  in  1  synchronous, active-high reset.
- slow_ce_i  in  1  occupancy sample strobe (~1 kHz).
- micro_ce_i  in  1  deadtime tick strobe (~1 MHz).
- pps_i  in  1  one-cycle PPS strobe.
- block_req_i  in  REQ_WIDTH  blocks locked this cycle (0 = none).
- block_done_i  in  REQ_WIDTH  blocks freed this cycle.
- trig_i  in  1  trigger arrival strobe.
- high_water_i  in  CNT_WIDTH  dead-entry threshold, static between writes.
- low_water_i  in  CNT_WIDTH  dead-exit threshold.
- irs_dead_i  in  1  external dead (digitizer busy).
- err_clr_i  in  1  clears err_o.
- dead_o  out  1  trigger inhibit.
- deadtime_o  out  STAT_WIDTH  latched deadtime per second.
- occupancy_o  out  STAT_WIDTH  latched windowed average occupancy.
- max_occupancy_o  out  STAT_WIDTH  latched per-second max occupancy.
- inhibit_count_o  out  STAT_WIDTH  latched per-second count of triggers arriving while dead_o.
- err_o  out  2  sticky flags: [0] overflow, [1] underflow.

Behaviour:
- Reset: all counters, latches and the dead register go to 0; every output is 0. dead_o is 0 unless irs_dead_i is high.
- Counter update: count <= count + block_req_i - block_done_i, computed at CNT_WIDTH+1 bits.
  - Result <0 saturates to 0.
  - Result >2^CNT_WIDTH-1 saturates to all-ones.
  - Simultaneous equal request and release leaves the count unchanged.
- Dead register, states IDLE/DEAD:
  - IDLE->DEAD the cycle after count >= high_water_i.
  - In DEAD, hysteresis counter increments each cycle with count < low_water_i; it clears otherwise.
  - DEAD->IDLE when the hysteresis counter reaches HYST_CYCLES; the counter then clears.
  - If low_water_i > high_water_i, exit uses high_water_i as the low mark.
- dead_o = dead register OR irs_dead_i (combinational OR, registered term).
- Deadtime: increments on micro_ce_i while dead_o, saturating at all-ones.
  - On pps_i: deadtime_o <= accumulator top STAT_WIDTH bits, and the accumulator <= 0. The increment on the pps cycle is discarded.
- Occupancy: accumulator (CNT_WIDTH+OCC_WINDOW_LOG2 bits) adds count on each slow_ce_i.
  - On the 2^OCC_WINDOW_LOG2-th sample, occupancy_o <= (accum + count) >> OCC_WINDOW_LOG2, saturated to STAT_WIDTH. The accumulator then restarts at 0.
  - Window is free-running; not aligned to PPS.
- Max occupancy: running max of count, saturated to STAT_WIDTH.
  - On pps_i, max_occupancy_o <= running max, and the running max restarts at the current count (not 0).
- Inhibit count: increments on trig_i && dead_o, saturating.
  - On pps_i it is latched and cleared; a trig on the pps cycle counts toward the new second.
- Latency: dead_o rises 1 cycle after the threshold is crossed. Statistics update 1 cycle after their strobe.
- Reset mid-second: statistics restart; the next pps latches a partial second.

Optional Feature:
- IRS_OCC_ERR_EN defined: err_o[0] sets when the counter saturates high; err_o[1] sets when release exceeds count. Flags are sticky until rst_i or err_clr_i. On a same-cycle set and clear, set wins.
- Undefined: err_o tied 0 and err_clr_i ignored; saturation still applies.

Decomposition:
- Package irs_monitor_pkg: parameter defaults, the IDLE/DEAD state encoding, and a saturating-add width helper.
- One sub-module, irs_pps_stat_counter: a saturating counter with increment enable and PPS latch/clear, instantiated for deadtime and inhibit count.

Test Plan:
- Defaults, high_water=100, low_water=90, block_req_i=3 per cycle for 34 cycles -> count=102; dead_o high on the cycle after count reaches 102. Then block_done_i=2 per cycle until count=88, held -> dead_o drops exactly 4 cycles after count <90.
- block_req_i=2 and block_done_i=2 for 50 cycles from count=10 -> count stays 10, no dead.
- Count=1, block_done_i=3 -> count=0; err_o=2'b10 with IRS_OCC_ERR_EN, 0 without. err_clr_i -> err_o=0.
- dead_o held 500 000 micro_ce_i ticks, then pps_i -> deadtime_o=0x7A. Next pps with no dead -> 0.
- Constant count=40 over 16 slow_ce_i -> occupancy_o=40. Count=300 -> occupancy_o=255 and max_occupancy_o=255 after pps.
- 5 trig_i while dead plus 1 on the pps cycle -> inhibit_count_o=5, next second starts at 1. rst_i asserted mid-run -> all outputs 0 the next cycle.
